stack_controller: RTL and testbench

Sequencer and arbiter in front of the 64-entry return-address stack file. Shares the stack between two requesters, the CPU control unit (call/return) and the interrupt unit (entry/exit). It grants one operation at a time, drives the stack file's enable/write strobes, tracks depth, blocks overflow and underflow before they reach the storage, and returns popped addresses with a one-cycle valid pulse tagged by owner.

---
 rtl/stack_controller_pkg.sv | 34 +++
 rtl/stack_rr_arbiter.sv | 29 ++
 rtl/stack_controller.sv | 150 +++++++++++++++
 tb/tb_stack_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_controller_pkg.sv
// Shared types and constants for the return-address stack controller.
// Also holds the op encoding used by the control and interrupt units.
package stack_controller_pkg;

    localparam int DEPTH   = 64;
    localparam int ADDR_W  = 8;
    localparam int DEPTH_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ISSUE   = 2'b01,
        S_CAPTURE = 2'b10
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_UNF  = 2'b10;
    localparam logic [1:0] ERR_BOTH = 2'b11;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_INT = 1'b1;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    // A push needs a free slot, a pop needs a filled one.
    function automatic logic op_legal(input logic op,
                                      input logic [DEPTH_W-1:0] depth);
        if (op == OP_PUSH)
            return depth < DEPTH_W'(DEPTH);
        return depth != '0;
    endfunction

endpackage

// File: rtl/stack_rr_arbiter.sv
// Two-way round-robin grant between the CPU and interrupt requesters.
// The preference pointer flips on every grant taken.
module stack_rr_arbiter
    import stack_controller_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_cpu,
    input  logic req_int,
    input  logic take,
    output logic grant_own
);

    logic fav_int;

    always_comb begin
        grant_own = OWN_CPU;
        if (req_int && (!req_cpu || fav_int))
            grant_own = OWN_INT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fav_int <= 1'b0;
        else if (take)
            fav_int <= ~fav_int;
    end

endmodule

// File: rtl/stack_controller.sv
// Arbitrating sequencer in front of the return-address stack file:
// grants one push/pop at a time, guards depth and reports errors.
module stack_controller
    import stack_controller_pkg::*;
(
    input  logic               Sys_Clock,
    input  logic               Reset_N,
    input  logic               Cpu_Req,
    input  logic               Cpu_Op,
    input  logic [ADDR_W-1:0]  Cpu_Data,
    output logic               Cpu_Ack,
    input  logic               Int_Req,
    input  logic               Int_Op,
    input  logic [ADDR_W-1:0]  Int_Data,
    output logic               Int_Ack,
    input  logic               Flush,
    input  logic               Err_Clear,
    input  logic [ADDR_W-1:0]  Ret_Data,
    output logic               Stack_Enable,
    output logic               Stack_Write,
    output logic [ADDR_W-1:0]  NPPC,
    output logic               Stack_Clear,
    output logic               Ret_Valid,
    output logic [ADDR_W-1:0]  Ret_Add_Out,
    output logic               Ret_Owner,
    output logic [DEPTH_W-1:0] Depth,
    output logic               Full,
    output logic               Empty,
    output logic               Err_Out,
    output logic [1:0]         Err_Code
);

    state_e             state;
    logic [DEPTH_W-1:0] depth;
    logic               own_q;
    logic               op_q;
    logic               legal_q;
    logic               flush_pend;
    logic               clr_q;
    logic [1:0]         err_code;

    logic               grant_own;
    logic               sel_op;
    logic [ADDR_W-1:0]  sel_data;
    logic               sel_legal;
    logic               flush_now;
    logic               take;
    logic [1:0]         new_err;

    stack_rr_arbiter u_arb (
        .clk       (Sys_Clock),
        .rst_n     (Reset_N),
        .req_cpu   (Cpu_Req),
        .req_int   (Int_Req),
        .take      (take),
        .grant_own (grant_own)
    );

    always_comb begin
        sel_op    = (grant_own == OWN_INT) ? Int_Op : Cpu_Op;
        sel_data  = (grant_own == OWN_INT) ? Int_Data : Cpu_Data;
        sel_legal = op_legal(sel_op, depth);
        flush_now = Flush || flush_pend;
        take      = (state == S_IDLE) && !flush_now
                    && (Cpu_Req || Int_Req);
        new_err   = ERR_NONE;
        if (state == S_ISSUE && !legal_q)
            new_err = (op_q == OP_PUSH) ? ERR_OVF : ERR_UNF;
    end

    always_ff @(posedge Sys_Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state        <= S_IDLE;
            depth        <= '0;
            own_q        <= OWN_CPU;
            op_q         <= OP_POP;
            legal_q      <= 1'b0;
            flush_pend   <= 1'b0;
            clr_q        <= 1'b0;
            err_code     <= ERR_NONE;
            Cpu_Ack      <= 1'b0;
            Int_Ack      <= 1'b0;
            Stack_Enable <= 1'b0;
            Stack_Write  <= 1'b0;
            NPPC         <= '0;
            Ret_Valid    <= 1'b0;
            Ret_Add_Out  <= '0;
            Ret_Owner    <= OWN_CPU;
        end else begin
            Cpu_Ack      <= 1'b0;
            Int_Ack      <= 1'b0;
            Stack_Enable <= 1'b0;
            Stack_Write  <= 1'b0;
            Ret_Valid    <= 1'b0;
            clr_q        <= 1'b0;

            // A fresh error outranks a simultaneous clear.
            if (Err_Clear)
                err_code <= new_err;
            else
                err_code <= err_code | new_err;

            unique case (state)
                S_IDLE: begin
                    if (flush_now) begin
                        depth      <= '0;
                        clr_q      <= 1'b1;
                        flush_pend <= 1'b0;
                    end else if (take) begin
                        own_q        <= grant_own;
                        op_q         <= sel_op;
                        legal_q      <= sel_legal;
                        NPPC         <= sel_data;
                        Stack_Enable <= sel_legal;
                        Stack_Write  <= sel_legal && (sel_op == OP_PUSH);
                        Cpu_Ack      <= (grant_own == OWN_CPU);
                        Int_Ack      <= (grant_own == OWN_INT);
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    flush_pend <= flush_pend || Flush;
                    state      <= S_IDLE;
                    if (legal_q && op_q == OP_PUSH)
                        depth <= depth + 1'b1;
                    if (legal_q && op_q == OP_POP) begin
                        depth       <= depth - 1'b1;
                        Ret_Valid   <= 1'b1;
                        Ret_Add_Out <= Ret_Data;
                        Ret_Owner   <= own_q;
                        state       <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    flush_pend <= flush_pend || Flush;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Stack_Clear = clr_q || !Reset_N;
    assign Depth       = depth;
    assign Full        = (depth == DEPTH_W'(DEPTH));
    assign Empty       = (depth == '0);
    assign Err_Code    = err_code;
    assign Err_Out     = |err_code;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: directed steps plus random traffic
// against a queue-based model of the stack and arbitration.
module tb_stack_controller;
    import stack_controller_pkg::*;

    logic              Sys_Clock = 1'b0;
    logic              Reset_N;
    logic              Cpu_Req, Cpu_Op, Int_Req, Int_Op;
    logic [7:0]        Cpu_Data, Int_Data;
    logic              Cpu_Ack, Int_Ack;
    logic              Flush, Err_Clear;
    logic [7:0]        Ret_Data;
    logic              Stack_Enable, Stack_Write, Stack_Clear;
    logic [7:0]        NPPC, Ret_Add_Out;
    logic              Ret_Valid, Ret_Owner;
    logic [6:0]        Depth;
    logic              Full, Empty, Err_Out;
    logic [1:0]        Err_Code;

    stack_controller dut (
        .Sys_Clock    (Sys_Clock),
        .Reset_N      (Reset_N),
        .Cpu_Req      (Cpu_Req),
        .Cpu_Op       (Cpu_Op),
        .Cpu_Data     (Cpu_Data),
        .Cpu_Ack      (Cpu_Ack),
        .Int_Req      (Int_Req),
        .Int_Op       (Int_Op),
        .Int_Data     (Int_Data),
        .Int_Ack      (Int_Ack),
        .Flush        (Flush),
        .Err_Clear    (Err_Clear),
        .Ret_Data     (Ret_Data),
        .Stack_Enable (Stack_Enable),
        .Stack_Write  (Stack_Write),
        .NPPC         (NPPC),
        .Stack_Clear  (Stack_Clear),
        .Ret_Valid    (Ret_Valid),
        .Ret_Add_Out  (Ret_Add_Out),
        .Ret_Owner    (Ret_Owner),
        .Depth        (Depth),
        .Full         (Full),
        .Empty        (Empty),
        .Err_Out      (Err_Out),
        .Err_Code     (Err_Code)
    );

    always #5 Sys_Clock = ~Sys_Clock;

    // Stack file: acts on the falling edge of the strobe cycle.
    logic [7:0] mem [64];
    int         sp = 0;
    always @(negedge Sys_Clock) begin
        if (Stack_Clear) begin
            sp <= 0;
        end else if (Stack_Enable) begin
            if (Stack_Write) begin
                mem[sp] <= NPPC;
                sp      <= sp + 1;
            end else begin
                Ret_Data <= mem[sp-1];
                sp       <= sp - 1;
            end
        end
    end

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] m_q[$];
    logic [1:0] m_err = 2'b00;
    logic       m_fav = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_req(input logic own, input logic op,
                           input logic [7:0] d);
        if (own == OWN_INT) begin
            Int_Req = 1'b1; Int_Op = op; Int_Data = d;
        end else begin
            Cpu_Req = 1'b1; Cpu_Op = op; Cpu_Data = d;
        end
    endtask

    task automatic check_status();
        check("depth", 32'(Depth), 32'(m_q.size()));
        check("full", 32'(Full), 32'(m_q.size() == 64));
        check("empty", 32'(Empty), 32'(m_q.size() == 0));
        check("err_code", 32'(Err_Code), 32'(m_err));
        check("err_out", 32'(Err_Out), 32'(m_err != 2'b00));
    endtask

    // Waits for the grant of the expected requester and checks the
    // whole transaction; returns with the controller back in IDLE.
    task automatic serve(input logic own, input logic op,
                         input logic [7:0] d, input int lat);
        int         n = 0;
        bit         legal;
        logic [7:0] exp_d = 8'h00;
        do begin
            @(negedge Sys_Clock);
            n++;
        end while (!(Cpu_Ack || Int_Ack) && n < 12);
        check("ack_seen", 32'(Cpu_Ack || Int_Ack), 32'd1);
        if (lat > 0)
            check("ack_latency", n, lat);
        legal = op ? (m_q.size() < 64) : (m_q.size() > 0);
        check("cpu_ack", 32'(Cpu_Ack), 32'(own == OWN_CPU));
        check("int_ack", 32'(Int_Ack), 32'(own == OWN_INT));
        check("stack_en", 32'(Stack_Enable), 32'(legal));
        check("stack_wr", 32'(Stack_Write), 32'(legal && op));
        if (legal && op)
            check("nppc", 32'(NPPC), 32'(d));
        if (own == OWN_INT) Int_Req = 1'b0;
        else Cpu_Req = 1'b0;
        m_fav = ~m_fav;
        @(negedge Sys_Clock);
        if (!legal)
            m_err = m_err | (op ? 2'b01 : 2'b10);
        else if (op)
            m_q.push_back(d);
        else
            exp_d = m_q.pop_back();
        check("ret_valid", 32'(Ret_Valid), 32'(legal && !op));
        if (legal && !op) begin
            check("ret_addr", 32'(Ret_Add_Out), 32'(exp_d));
            check("ret_owner", 32'(Ret_Owner), 32'(own));
        end
        check("one_strobe", 32'(Stack_Enable), 32'd0);
        check_status();
        if (legal && !op)
            @(negedge Sys_Clock);
    endtask

    task automatic single(input logic own, input logic op,
                          input logic [7:0] d);
        set_req(own, op, d);
        serve(own, op, d, 1);
    endtask

    task automatic conflict(input logic op_c, input logic [7:0] d_c,
                            input logic op_i, input logic [7:0] d_i);
        set_req(OWN_CPU, op_c, d_c);
        set_req(OWN_INT, op_i, d_i);
        if (m_fav == OWN_INT) begin
            serve(OWN_INT, op_i, d_i, 1);
            serve(OWN_CPU, op_c, d_c, 0);
        end else begin
            serve(OWN_CPU, op_c, d_c, 1);
            serve(OWN_INT, op_i, d_i, 0);
        end
    endtask

    task automatic do_flush();
        Flush = 1'b1;
        @(negedge Sys_Clock);
        Flush = 1'b0;
        m_q.delete();
        check("flush_clear", 32'(Stack_Clear), 32'd1);
        check("flush_depth", 32'(Depth), 32'd0);
        @(negedge Sys_Clock);
        check("flush_pulse", 32'(Stack_Clear), 32'd0);
    endtask

    task automatic do_err_clear();
        Err_Clear = 1'b1;
        @(negedge Sys_Clock);
        Err_Clear = 1'b0;
        m_err = 2'b00;
        check("errclr_code", 32'(Err_Code), 32'd0);
        check("errclr_out", 32'(Err_Out), 32'd0);
    endtask

    initial begin
        int         n;
        int         r;
        logic       op;
        Reset_N = 1'b0;
        Cpu_Req = 0; Cpu_Op = 0; Cpu_Data = 0;
        Int_Req = 0; Int_Op = 0; Int_Data = 0;
        Flush = 0; Err_Clear = 0;
        #1;
        check("rst_clear", 32'(Stack_Clear), 32'd1);
        repeat (2) @(negedge Sys_Clock);
        check("rst_ack", 32'({Cpu_Ack, Int_Ack}), 32'd0);
        check("rst_strobe", 32'({Stack_Enable, Stack_Write}), 32'd0);
        check("rst_retv", 32'(Ret_Valid), 32'd0);
        check("rst_retaddr", 32'(Ret_Add_Out), 32'd0);
        check("rst_nppc", 32'(NPPC), 32'd0);
        check_status();
        Reset_N = 1'b1;
        @(negedge Sys_Clock);
        check("clear_off", 32'(Stack_Clear), 32'd0);

        single(OWN_CPU, OP_PUSH, 8'h12);
        single(OWN_CPU, OP_PUSH, 8'h34);
        single(OWN_CPU, OP_POP, 8'h00);
        single(OWN_CPU, OP_POP, 8'h00);

        repeat (3) conflict(OP_PUSH, 8'($urandom), OP_PUSH, 8'($urandom));

        single(OWN_INT, OP_POP, 8'h00);
        check("pre_flush_depth", 32'(Depth), 32'd5);
        do_flush();
        single(OWN_CPU, OP_POP, 8'h00);
        single(OWN_CPU, OP_PUSH, 8'hA5);
        check("err_sticky", 32'(Err_Code), 32'd2);
        do_err_clear();
        do_flush();

        for (int i = 0; i < 64; i++)
            single(OWN_CPU, OP_PUSH, 8'($urandom));
        check("fill_full", 32'(Full), 32'd1);
        single(OWN_INT, OP_PUSH, 8'h77);
        check("ovf_depth", 32'(Depth), 32'd64);
        check("ovf_code", 32'(Err_Code), 32'd1);
        do_err_clear();
        do_flush();

        for (int i = 0; i < 120; i++) begin
            r  = int'($urandom_range(0, 9));
            op = (m_q.size() < 2) ? ($urandom_range(0, 3) != 0)
                                  : ($urandom_range(0, 1) != 0);
            if (r <= 3)
                single(OWN_CPU, op, 8'($urandom));
            else if (r <= 6)
                single(OWN_INT, op, 8'($urandom));
            else if (r <= 8)
                conflict(op, 8'($urandom), $urandom_range(0, 1) != 0,
                         8'($urandom));
            else if ($urandom_range(0, 1) != 0)
                do_flush();
            else
                do_err_clear();
        end

        single(OWN_CPU, OP_PUSH, 8'h5A);
        set_req(OWN_CPU, OP_POP, 8'h00);
        n = 0;
        do begin
            @(negedge Sys_Clock);
            n++;
        end while (!Cpu_Ack && n < 12);
        check("mid_ack_seen", 32'(Cpu_Ack), 32'd1);
        Cpu_Req = 1'b0;
        @(posedge Sys_Clock);
        #1 Reset_N = 1'b0;
        #1;
        check("mid_retv", 32'(Ret_Valid), 32'd0);
        check("mid_depth", 32'(Depth), 32'd0);
        check("mid_clear", 32'(Stack_Clear), 32'd1);
        @(negedge Sys_Clock);
        check("mid_ack", 32'({Cpu_Ack, Int_Ack}), 32'd0);
        Reset_N = 1'b1;
        m_q.delete();
        m_err = 2'b00;
        m_fav = 1'b0;
        @(negedge Sys_Clock);
        check_status();
        check("post_rst_retv", 32'(Ret_Valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
